// File: rtl/cba_pkg.sv
// Shared helpers for the pipelined carry-bypass adder.
// Geometry functions and the signed-overflow rule.
package cba_pkg;

    function automatic int nstage(
        input int width,
        input int blk,
        input int pipe_blks
    );
        return width / (blk * pipe_blks);
    endfunction

    function automatic int nblk(
        input int width,
        input int blk
    );
        return width / blk;
    endfunction

    function automatic logic ovf_of(
        input logic a_msb,
        input logic bx_msb,
        input logic s_msb
    );
        return (a_msb == bx_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cba_pipe_adder_if.sv
// Operand/result streaming bundle for the pipelined adder.
// Producer-and-consumer side is master, the adder is slave.
interface cba_pipe_adder_if
    import cba_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLK   = 4
) ();
    logic                         in_valid;
    logic                         in_ready;
    logic [WIDTH-1:0]             a;
    logic [WIDTH-1:0]             b;
    logic                         cin;
    logic                         sub;
    logic                         out_valid;
    logic                         out_ready;
    logic [WIDTH-1:0]             sum;
    logic                         cout;
    logic                         ovf;
    logic [nblk(WIDTH, BLK)-1:0]  bypass;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, bypass
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, bypass
    );
endinterface

// File: rtl/cba_block.sv
// One carry-skip block: ripple inside, bypass mux on the carry out.
module cba_block #(
    parameter int BLK = 4
) (
    input  logic [BLK-1:0] a,
    input  logic [BLK-1:0] bx,
    input  logic           cin,
    output logic [BLK-1:0] s,
    output logic           cout,
    output logic           p
);
    logic [BLK-1:0] t;
    logic [BLK:0]   c;

    assign t = a ^ bx;
    assign p = &t;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLK; i++) begin
            c[i+1] = (a[i] & bx[i]) | (c[i] & t[i]);
        end
    end

    assign s    = t ^ c[BLK-1:0];
    assign cout = p ? cin : c[BLK];
endmodule

// File: rtl/cba_pipe_adder.sv
// Pipelined carry-bypass adder/subtractor with a global stall enable.
module cba_pipe_adder
    import cba_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BLK       = 4,
    parameter int PIPE_BLKS = 2
) (
    input logic             clk,
    input logic             rst_n,
    cba_pipe_adder_if.slave io
);
    localparam int NSTAGE = nstage(WIDTH, BLK, PIPE_BLKS);
    localparam int NBLK   = nblk(WIDTH, BLK);
    localparam int SW     = BLK * PIPE_BLKS;

    if ((WIDTH % SW) != 0 || BLK < 2) begin : g_bad_cfg
        $error("cba_pipe_adder: bad WIDTH/BLK/PIPE_BLKS");
    end

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] sum_lo;
        logic [WIDTH-1:0] a_hi;
        logic [WIDTH-1:0] bx_hi;
        logic             carry;
        logic [NBLK-1:0]  bypass_lo;
    } stage_t;

    stage_t r   [NSTAGE+1];
    stage_t nxt [NSTAGE];
    stage_t acc;
    logic   en;

    assign en          = !r[NSTAGE].valid || io.out_ready;
    assign io.in_ready = en;

    always_comb begin
        acc       = '0;
        acc.valid = io.in_valid;
        acc.a_hi  = io.a;
        acc.bx_hi = io.sub ? ~io.b : io.b;
        acc.carry = io.sub ? 1'b1 : io.cin;
    end

    // r[k] feeds stage k; r[NSTAGE] is the output register
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
        logic [SW-1:0]        s;
        logic [PIPE_BLKS-1:0] p;
        stage_t               nx;

        for (genvar i = 0; i < PIPE_BLKS; i++) begin : g_blk
            localparam int J = k * PIPE_BLKS + i;
            logic ci;
            logic co;

            if (i == 0) begin : g_first
                assign ci = r[k].carry;
            end else begin : g_next
                assign ci = g_blk[i-1].co;
            end

            cba_block #(
                .BLK(BLK)
            ) u_blk (
                .a   (r[k].a_hi[J*BLK +: BLK]),
                .bx  (r[k].bx_hi[J*BLK +: BLK]),
                .cin (ci),
                .s   (s[i*BLK +: BLK]),
                .cout(co),
                .p   (p[i])
            );
        end

        always_comb begin
            nx = r[k];
            nx.sum_lo[k*SW +: SW]                  = s;
            nx.bypass_lo[k*PIPE_BLKS +: PIPE_BLKS] = p;
            nx.carry                               = g_blk[PIPE_BLKS-1].co;
        end

        assign nxt[k] = nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k <= NSTAGE; k++) begin
                r[k] <= '0;
            end
        end else if (en) begin
            r[0] <= acc;
            for (int k = 0; k < NSTAGE; k++) begin
                r[k+1] <= nxt[k];
            end
        end
    end

    assign io.out_valid = r[NSTAGE].valid;
    assign io.sum       = r[NSTAGE].sum_lo;
    assign io.cout      = r[NSTAGE].carry;
    assign io.bypass    = r[NSTAGE].bypass_lo;
    assign io.ovf       = ovf_of(r[NSTAGE].a_hi[WIDTH-1],
                                 r[NSTAGE].bx_hi[WIDTH-1],
                                 r[NSTAGE].sum_lo[WIDTH-1]);
endmodule

// File: tb/tb_cba_pipe_adder.sv
// Bench for cba_pipe_adder: vector table, corner sequences, random scoreboard.
module tb_cba_pipe_adder;
    localparam int W  = 32;
    localparam int B  = 4;
    localparam int PB = 2;
    localparam int NS = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    cba_pipe_adder_if #(.WIDTH(W), .BLK(B)) io ();

    cba_pipe_adder #(
        .WIDTH    (W),
        .BLK      (B),
        .PIPE_BLKS(PB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io)
    );

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic [7:0]  byp;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        res_t        exp;
    } vec_t;

    res_t exp_q[$];
    vec_t tbl[8];
    int   tot  = 0;
    int   pass = 0;

    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        res_t        r;
        logic [31:0] bx;
        logic [32:0] t;
        bx    = sub ? ~b : b;
        t     = {1'b0, a} + {1'b0, bx} + {32'd0, (sub ? 1'b1 : cin)};
        r.sum = t[31:0];
        r.cout = t[32];
        r.ovf = (a[31] == bx[31]) && (t[31] != a[31]);
        for (int j = 0; j < 8; j++) begin
            r.byp[j] = &(a[j*4 +: 4] ^ bx[j*4 +: 4]);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tot++;
        if (act === exp) pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cycle(output bit ix, output bit ox);
        res_t e;
        ix = 0;
        ox = 0;
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            chk("in_ready_rule", io.in_ready, !io.out_valid || io.out_ready);
            ox = io.out_valid && io.out_ready;
            ix = io.in_valid && io.in_ready;
            if (ox) begin
                if (exp_q.size() == 0) begin
                    tot++;
                    $display("FAIL unexpected_result: got sum %0h, expected none",
                             io.sum);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", {io.cout, io.ovf, io.bypass, io.sum},
                        {e.cout, e.ovf, e.byp, e.sum});
                end
            end
            if (ix) exp_q.push_back(model(io.a, io.b, io.cin, io.sub));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        bit ix, ox;
        cycle(ix, ox);
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic sub);
        io.a        = a;
        io.b        = b;
        io.cin      = cin;
        io.sub      = sub;
        io.in_valid = 1'b1;
    endtask

    task automatic drain();
        io.in_valid  = 1'b0;
        io.out_ready = 1'b1;
        repeat (NS + 2) step();
    endtask

    initial begin
        bit          ix, ox;
        int          lat, sent, got, stall, seen;
        bit          started;
        logic [31:0] held, ra, rb;
        bit          pat[4];

        tbl[0] = '{32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, '{32'h0, 1'b1, 1'b0, 8'hFF}};
        tbl[1] = '{32'h5, 32'h7, 1'b0, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0, 8'hFE}};
        tbl[2] = '{32'h8000_0000, 32'h1, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1, 8'h7E}};
        tbl[3] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1, 8'h7E}};
        tbl[4] = '{32'h0, 32'h0, 1'b0, 1'b1, '{32'h0, 1'b1, 1'b0, 8'hFF}};
        tbl[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, '{32'h2345_6789, 1'b0, 1'b0, 8'h00}};
        tbl[6] = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b0, 1'b0, '{32'hFFFF_FFFF, 1'b0, 1'b0, 8'hFF}};
        tbl[7] = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 1'b1, 1'b0, '{32'h0, 1'b1, 1'b0, 8'hFF}};

        io.in_valid  = 1'b0;
        io.a         = '0;
        io.b         = '0;
        io.cin       = 1'b0;
        io.sub       = 1'b0;
        io.out_ready = 1'b1;

        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_out_valid", io.out_valid, 0);
        chk("rst_sum", io.sum, 0);
        chk("rst_cout", io.cout, 0);
        chk("rst_ovf", io.ovf, 0);
        chk("rst_bypass", io.bypass, 0);
        chk("rst_in_ready", io.in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
            step();
            io.in_valid = 1'b0;
            lat = 0;
            do begin
                step();
                lat++;
            end while (!io.out_valid && lat < 10);
            chk($sformatf("tbl%0d_latency", i), lat, NS);
            chk($sformatf("tbl%0d_sum", i), io.sum, tbl[i].exp.sum);
            chk($sformatf("tbl%0d_cout", i), io.cout, tbl[i].exp.cout);
            chk($sformatf("tbl%0d_ovf", i), io.ovf, tbl[i].exp.ovf);
            chk($sformatf("tbl%0d_bypass", i), io.bypass, tbl[i].exp.byp);
        end
        drain();

        drive(32'h5, 32'h7, 1'b0, 1'b1);
        step();
        drive(32'h8000_0000, 32'h1, 1'b0, 1'b1);
        step();
        io.in_valid = 1'b0;
        repeat (3) step();
        chk("sub1_valid", io.out_valid, 1);
        chk("sub1_sum", io.sum, 32'hFFFF_FFFE);
        chk("sub1_cout", io.cout, 0);
        chk("sub1_ovf", io.ovf, 0);
        step();
        chk("sub2_valid", io.out_valid, 1);
        chk("sub2_sum", io.sum, 32'h7FFF_FFFF);
        chk("sub2_cout", io.cout, 1);
        chk("sub2_ovf", io.ovf, 1);
        drain();

        sent    = 0;
        got     = 0;
        stall   = 0;
        started = 0;
        held    = '0;
        for (int c = 0; c < 60 && got < 6; c++) begin
            if (!started && io.out_valid) begin
                started = 1;
                stall   = 5;
                held    = io.sum;
            end
            io.out_ready = (stall == 0);
            if (sent < 6) drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
            else io.in_valid = 1'b0;
            cycle(ix, ox);
            sent += int'(ix);
            got  += int'(ox);
            if (stall > 0) begin
                chk("bp_in_ready", io.in_ready, 0);
                chk("bp_hold_sum", io.sum, held);
                chk("bp_hold_valid", io.out_valid, 1);
                stall--;
            end
        end
        chk("bp_sent", sent, 6);
        chk("bp_got", got, 6);
        drain();

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive($urandom, $urandom, 1'b0, 1'b0);
            io.in_valid = pat[i];
            step();
        end
        io.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("bubble%0d_valid", i), io.out_valid, pat[i]);
        end
        drain();

        repeat (3) begin
            drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            step();
        end
        io.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_out_valid", io.out_valid, 0);
        chk("midrst_sum", io.sum, 0);
        chk("midrst_cout", io.cout, 0);
        chk("midrst_ovf", io.ovf, 0);
        chk("midrst_bypass", io.bypass, 0);
        seen = 0;
        repeat (10) begin
            step();
            if (io.out_valid) seen++;
        end
        chk("midrst_no_result", seen, 0);

        sent = 0;
        for (int c = 0; c < 60000 && sent < 20000; c++) begin
            io.out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) != 0) begin
                ra = $urandom;
                case ($urandom_range(0, 3))
                    0:       rb = ra;
                    1:       rb = ~ra;
                    default: rb = $urandom;
                endcase
                drive(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                io.in_valid = 1'b0;
            end
            cycle(ix, ox);
            sent += int'(ix);
        end
        chk("rand_sent", sent, 20000);
        drain();
        chk("rand_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass, tot);
        $finish;
    end
endmodule

// File: doc/cba_pipe_adder.md
Name: cba_pipe_adder

Overview:
- Parametrised, pipelined carry-bypass (carry-skip) adder/subtractor. Successor to the fixed 16-bit combinational carry-bypass adder.
- Operand width, skip-block size and pipeline depth are generic. Adds subtract mode, signed-overflow flag and per-block bypass visibility.
- Valid/ready handshake on input and output, so it drops into streaming datapaths with backpressure.

Parameters:
- WIDTH, 32, operand/sum width; must be a multiple of BLK*PIPE_BLKS.
- BLK, 4, bits per skip block (ripple inside, bypass mux across).
- PIPE_BLKS, 2, skip blocks per pipeline stage; NSTAGE = WIDTH/(BLK*PIPE_BLKS).

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: synchronous reset, active low.
- in_valid, in, 1: operands valid.
- in_ready, out, 1: adder accepts operands this cycle.
- a, in, WIDTH: operand A.
- b, in, WIDTH: operand B.
- cin, in, 1: carry in; ignored when sub=1.
- sub, in, 1: 0 = a+b+cin; 1 = a-b (a + ~b + 1).
- out_valid, out, 1: result valid.
- out_ready, in, 1: consumer accepts result.
- sum, out, WIDTH: result.
- cout, out, 1: carry out of MSB (for sub, 1 = no borrow).
- ovf, out, 1: two's-complement signed overflow.
- bypass, out, WIDTH/BLK: bit j = 1 when block j selected its carry via the skip path (all propagate bits of block j = 1).

Behaviour:
- Reset (rst_n=0 at a clk edge): all stage valid bits clear. out_valid, sum, cout, ovf, bypass = 0. in_ready = 1 on the first cycle after reset release. Reset mid-operation discards all in-flight results; no partial result ever appears.
- Effective B: bx = sub ? ~b : b. Effective carry in: cx = sub ? 1 : cin. Both are computed at acceptance.
- Block j: p_j = &(a_j ^ bx_j). c_out_j = p_j ? c_in_j : ripple_carry_j. bypass[j] = p_j.
- Stage k computes blocks k*PIPE_BLKS .. (k+1)*PIPE_BLKS-1 from the carry registered by stage k-1 (stage 0 uses cx).
- Upper operand slices and already-computed lower sum/bypass slices travel in skew registers alongside each stage.
- Latency: a transfer accepted at edge t produces out_valid=1 after edge t+NSTAGE, assuming no stall. Throughput is one result per cycle.
- Stall rule: single global enable, en = !out_valid || out_ready. in_ready = en. All stage registers, valid bits included, advance only when en=1.
- Pipeline bubbles propagate as valid=0 and do not stall the pipe.
- While out_valid=1 and out_ready=0: sum, cout, ovf and bypass hold stable, and in_ready=0.
- Transfer at input: in_valid && in_ready. Transfer at output: out_valid && out_ready. Results leave in acceptance order.
- a, b, cin and sub are sampled only on an input transfer; values outside a transfer are don't-care.
- ovf = (a[MSB] == bx[MSB]) && (sum[MSB] != a[MSB]).
- Wrap-around: sum is modulo 2^WIDTH; cout carries the lost bit.
- Elaboration fails if WIDTH % (BLK*PIPE_BLKS) != 0 or BLK < 2.

Decomposition:
- Package cba_pkg: function nstage(WIDTH, BLK, PIPE_BLKS); localparam-style constants NBLK = WIDTH/BLK; stage-slice struct {valid, sum_lo, a_hi, bx_hi, carry, bypass_lo}.
- Sub-module cba_block: combinational BLK-bit ripple-plus-skip cell. Inputs a, bx, cin. Outputs s, cout, p. Instantiated NBLK times inside the stage generate loop.

Test Plan (WIDTH=32, BLK=4, PIPE_BLKS=2, NSTAGE=4):
- Full bypass chain: a=0xFFFF_FFFF, b=0, cin=1, sub=0, out_ready=1 -> exactly 4 cycles later sum=0x0000_0000, cout=1, ovf=0, bypass=0xFF.
- Subtract: a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0, ovf=0. Then a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, cout=1, ovf=1. Both results back-to-back, in order.
- Backpressure: issue 6 consecutive transfers and hold out_ready=0 from the cycle the first out_valid rises, for 5 cycles.
  - Required: in_ready=0 and sum held stable throughout.
  - After release, all 6 results emerge in order with no loss or duplication.
- Bubbles: in_valid pattern 1,0,0,1 -> out_valid pattern 1,0,0,1 starting 4 cycles later.
- Reset mid-flight: 3 transfers in flight, rst_n=0 for 1 cycle -> out_valid=0 and all outputs 0 the next cycle. None of the 3 results ever appears.
- Random: 20k transfers with random operands, sub, cin and out_ready -> every result matches the golden model {cout,sum} = a + bx + cx, plus the ovf and bypass formulas.
